// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load/store from the pipeline, checks alignment,
// performs the memory handshake, and returns aligned/extended load data or an error.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_st_size,
    input  logic [2:0]  req_ld_size,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [29:0] mem_addr,
    output logic        mem_rw,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  addrLow_q;
    logic [2:0]  ldSize_q;
    logic [29:0] memAddr_q;
    logic        memRw_q;
    logic [31:0] memWdata_q;
    logic [3:0]  memWmask_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  waitCnt_q;

    logic        acceptErr_d;
    logic [3:0]  storeMask_d;
    logic [31:0] storeData_d;
    logic [31:0] loadData_d;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    // Only the size field relevant to the operation kind can raise an error.
    always_comb begin
        acceptErr_d = 1'b0;
        if (req_we) begin
            case (req_st_size)
                2'b01:   acceptErr_d = req_addr[0];
                2'b10:   acceptErr_d = |req_addr[1:0];
                2'b11:   acceptErr_d = 1'b1;
                default: acceptErr_d = 1'b0;
            endcase
        end else begin
            case (req_ld_size)
                3'b001, 3'b101:         acceptErr_d = req_addr[0];
                3'b010:                 acceptErr_d = |req_addr[1:0];
                3'b011, 3'b110, 3'b111: acceptErr_d = 1'b1;
                default:                acceptErr_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        storeMask_d = 4'b1111;
        storeData_d = req_wdata;
        case (req_st_size)
            2'b00: begin
                storeMask_d = 4'b0001 << req_addr[1:0];
                storeData_d = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                storeMask_d = 4'b0011 << req_addr[1:0];
                storeData_d = {2{req_wdata[15:0]}};
            end
            default: begin
                storeMask_d = 4'b1111;
                storeData_d = req_wdata;
            end
        endcase
    end

    always_comb begin
        loadByte   = mem_resp_data[7:0];
        loadHalf   = addrLow_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
        loadData_d = mem_resp_data;
        case (addrLow_q)
            2'b00:   loadByte = mem_resp_data[7:0];
            2'b01:   loadByte = mem_resp_data[15:8];
            2'b10:   loadByte = mem_resp_data[23:16];
            default: loadByte = mem_resp_data[31:24];
        endcase
        case (ldSize_q)
            3'b000:  loadData_d = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadData_d = {{16{loadHalf[15]}}, loadHalf};
            3'b100:  loadData_d = {24'h0, loadByte};
            3'b101:  loadData_d = {16'h0, loadHalf};
            default: loadData_d = mem_resp_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addrLow_q  <= '0;
            ldSize_q   <= '0;
            memAddr_q  <= '0;
            memRw_q    <= 1'b0;
            memWdata_q <= '0;
            memWmask_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            waitCnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addrLow_q  <= req_addr[1:0];
                        ldSize_q   <= req_ld_size;
                        memAddr_q  <= req_addr[31:2];
                        memRw_q    <= req_we;
                        memWdata_q <= req_we ? storeData_d : 32'h0;
                        memWmask_q <= req_we ? storeMask_d : 4'h0;
                        rdata_q    <= '0;
                        err_q      <= acceptErr_d;
                        state_q    <= acceptErr_d ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        waitCnt_q <= '0;
                        state_q   <= memRw_q ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving on the timeout cycle still wins over the abort.
                    if (mem_resp_valid) begin
                        rdata_q <= loadData_d;
                        state_q <= DONE;
                    end else if (waitCnt_q == LAST_WAIT) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall         = (state_q == ISSUE) || (state_q == WAIT);
    assign resp_valid    = (state_q == DONE);
    assign resp_rdata    = resp_valid ? rdata_q : 32'h0;
    assign resp_err      = resp_valid & err_q;
    assign mem_req_valid = (state_q == ISSUE);
    assign mem_addr      = memAddr_q;
    assign mem_rw        = memRw_q;
    assign mem_wdata     = memWdata_q;
    assign mem_wmask     = memWmask_q;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in WAIT before a load is aborted; legal range 1..255.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  pipeline presents a memory op this cycle.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  store data, right-justified.
REQ-008 req_st_size  input  2  store func3[1:0]: 00 SB, 01 SH, 10 SW.
REQ-009 req_ld_size  input  3  load func3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 stall  output  1  pipeline must hold; combinational from state.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  aligned, extended load data; valid with resp_valid.
REQ-013 resp_err  output  1  misaligned, illegal size or timeout; valid with resp_valid.
REQ-014 mem_req_valid / mem_req_ready  output / input  1 / 1  memory request handshake.
REQ-015 mem_addr  output  30  word address (req_addr[31:2]).
REQ-016 mem_rw  output  1  1 = write.
REQ-017 mem_wdata / mem_wmask  output / output  32 / 4  lane-replicated write data, byte-enable mask.
REQ-018 mem_resp_valid / mem_resp_data  input / input  1 / 32  read return.

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: req_valid=1 SHALL register addr, data, we, sizes; next state ISSUE, or DONE with err if REQ-021 trips.
REQ-021 Error at acceptance: halfword with addr[0]=1, word with addr[1:0]!=0, st_size 11, or ld_size 011/110/111; no memory request SHALL be issued.
REQ-022 ISSUE: mem_req_valid=1 with registered fields held stable until mem_req_ready=1; then store -> DONE, load -> WAIT.
REQ-023 WAIT: mem_resp_valid=1 SHALL capture mem_resp_data and go DONE; mem_resp_valid outside WAIT SHALL be ignored.
REQ-024 WAIT: 8-bit counter cleared on entry, increments each cycle; reaching TIMEOUT without response SHALL go DONE with resp_err=1, resp_rdata=0.
REQ-025 DONE: resp_valid=1 for exactly one cycle; next state IDLE.
REQ-026 stall SHALL be 1 in ISSUE and WAIT, else 0; acceptance-to-resp_valid latency = 1 cycle for errors, >=2 for stores, >=3 for loads.
REQ-027 req_valid outside IDLE SHALL be ignored.
REQ-028 Store masks: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111. SB replicates byte to all lanes, SH replicates halfword to both halves.
REQ-029 Load: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-030 resp_rdata SHALL be 0 for stores and errors.
REQ-031 mem_addr/mem_rw/mem_wdata/mem_wmask SHALL be registered values; mem_wmask=0 when mem_rw=0.

Reset
REQ-032 reset SHALL asynchronously force IDLE and clear all registers; all outputs 0 while asserted, including mid-ISSUE or mid-WAIT.
REQ-033 After deassertion, a late mem_resp_valid for a pre-reset request SHALL be ignored.

Verification
REQ-034 SB addr 0x1003 wdata 0xA5, ready immediate -> mem_addr 0x400, mask 1000, wdata 0xA5A5A5A5, resp_valid 2 cycles after accept, err 0.
REQ-035 LB addr 0x2002, mem data 0x00800000 -> resp_rdata 0xFFFFFF80; same as LBU -> 0x00000080.
REQ-036 LW addr 0x10 with mem_req_ready held low 5 cycles -> stall high throughout, request fields stable, resp_valid after ready and data.
REQ-037 LH addr 0x3001 -> no mem_req_valid, resp_valid next cycle, resp_err 1.
REQ-038 TIMEOUT=4, load accepted, no mem_resp_valid -> resp_err 1, resp_rdata 0 after 4 WAIT cycles, then IDLE.
REQ-039 reset asserted in WAIT, response arrives after release -> outputs 0, no resp_valid, next req accepted normally.
